// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the DMEM port arbiter: FSM states, exclusion tags, DMEM load/store
// formats and the DMEM write-enable level.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_OWN0 = 2'd1,
        ARB_ST_OWN1 = 2'd2
    } arb_state_e;

    // Port barred from the next idle arbitration after its locked run hit the hold cap.
    typedef enum logic [1:0] {
        EXCL_NONE = 2'd0,
        EXCL_M0   = 2'd1,
        EXCL_M1   = 2'd2
    } arb_excl_e;

    localparam logic [2:0] LOAD_SEL_W  = 3'd0;
    localparam logic [2:0] LOAD_SEL_H  = 3'd1;
    localparam logic [2:0] LOAD_SEL_B  = 3'd2;
    localparam logic [2:0] LOAD_SEL_HU = 3'd3;
    localparam logic [2:0] LOAD_SEL_BU = 3'd4;

    localparam logic [1:0] STORE_SEL_W = 2'd0;
    localparam logic [1:0] STORE_SEL_H = 2'd1;
    localparam logic [1:0] STORE_SEL_B = 2'd2;

    localparam logic MEM_WRITE = 1'b1;

    function automatic arb_state_e own_state(input logic port);
        return port ? ARB_ST_OWN1 : ARB_ST_OWN0;
    endfunction

    function automatic arb_excl_e excl_of(input logic port);
        return port ? EXCL_M1 : EXCL_M0;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the DMEM arbiter: owner first, then idle arbitration.
// DMEM_ARB_RR_EN selects round-robin tie-break on last_win_i; otherwise m0 wins ties.
module dmem_arb_pick
    import dmem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_state_e state_i,
    input  arb_excl_e  excl_i,
`ifdef DMEM_ARB_RR_EN
    input  logic       last_win_i,
`endif
    output logic [1:0] gnt_o
);

    logic [1:0] elig;

    always_comb begin
        // The excluded port only sits out if the other one actually wants the port.
        elig = req_i;
        if ((excl_i == EXCL_M0) && req_i[1]) begin
            elig[0] = 1'b0;
        end
        if ((excl_i == EXCL_M1) && req_i[0]) begin
            elig[1] = 1'b0;
        end

        gnt_o = 2'b00;
        if ((state_i == ARB_ST_OWN0) && req_i[0]) begin
            gnt_o = 2'b01;
        end else if ((state_i == ARB_ST_OWN1) && req_i[1]) begin
            gnt_o = 2'b10;
        end else if (elig == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            gnt_o = last_win_i ? 2'b01 : 2'b10;
`else
            gnt_o = 2'b01;
`endif
        end else begin
            gnt_o = elig;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// DMEM port arbiter: shares one data-memory port between m0 (core LSU) and m1 (debug/DMA loader).
// Build option DMEM_ARB_RR_EN: round-robin idle arbitration; default is fixed priority, m0 first.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int MAX_HOLD  = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_load_sel,
    input  logic [1:0]  m0_store_sel,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_load_sel,
    input  logic [1:0]  m1_store_sel,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_w,
    output logic [2:0]  mem_load_sel,
    output logic [1:0]  mem_store_sel,
    output logic        mem_wr_en,
    input  logic [31:0] mem_data_r
);

    localparam int               HOLD_W      = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [29:0]      DEPTH_WORDS = 30'(MEM_DEPTH);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_base;
    arb_excl_e         excl_q, excl_d;
`ifdef DMEM_ARB_RR_EN
    logic              last_win_q, last_win_d;
`endif

    logic [1:0]  req;
    logic [1:0]  pick_gnt;
    logic [1:0]  gnt;
    logic        any_gnt;
    logic        win;
    logic        lock_w;
    logic        we_w;
    logic [31:0] addr_w;
    logic [31:0] wdata_w;
    logic [2:0]  lsel_w;
    logic [1:0]  ssel_w;
    logic        oor;

    assign req = {m1_req, m0_req};

    dmem_arb_pick u_pick (
        .req_i      (req),
        .state_i    (state_q),
        .excl_i     (excl_q),
`ifdef DMEM_ARB_RR_EN
        .last_win_i (last_win_q),
`endif
        .gnt_o      (pick_gnt)
    );

    // No access may be performed while reset is being sampled.
    assign gnt     = rst ? 2'b00 : pick_gnt;
    assign any_gnt = |gnt;
    assign win     = gnt[1];
    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];

    always_comb begin
        lock_w  = 1'b0;
        we_w    = 1'b0;
        addr_w  = '0;
        wdata_w = '0;
        lsel_w  = '0;
        ssel_w  = '0;
        if (gnt[0]) begin
            lock_w  = m0_lock;
            we_w    = m0_we;
            addr_w  = m0_addr;
            wdata_w = m0_wdata;
            lsel_w  = m0_load_sel;
            ssel_w  = m0_store_sel;
        end else if (gnt[1]) begin
            lock_w  = m1_lock;
            we_w    = m1_we;
            addr_w  = m1_addr;
            wdata_w = m1_wdata;
            lsel_w  = m1_load_sel;
            ssel_w  = m1_store_sel;
        end
    end

    assign oor           = (addr_w[31:2] >= DEPTH_WORDS);
    assign mem_addr      = addr_w;
    assign mem_data_w    = wdata_w;
    assign mem_load_sel  = lsel_w;
    assign mem_store_sel = ssel_w;
    assign mem_wr_en     = (any_gnt && we_w && !oor) ? MEM_WRITE : ~MEM_WRITE;

    always_comb begin
        state_d   = ARB_ST_IDLE;
        hold_d    = '0;
        excl_d    = EXCL_NONE;
        hold_base = '0;
        if (any_gnt) begin
            // Only a continuing owner carries its count; a fresh winner starts from zero.
            if (state_q == own_state(win)) begin
                hold_base = hold_q;
            end
            if (lock_w && (hold_base < HOLD_LAST)) begin
                state_d = own_state(win);
                hold_d  = hold_base + HOLD_W'(1);
            end else if (lock_w) begin
                excl_d = excl_of(win);
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    assign last_win_d = any_gnt ? win : last_win_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_ST_IDLE;
            hold_q     <= '0;
            excl_q     <= EXCL_NONE;
`ifdef DMEM_ARB_RR_EN
            last_win_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            excl_q     <= excl_d;
`ifdef DMEM_ARB_RR_EN
            last_win_q <= last_win_d;
`endif
        end
    end

    // Per-port response pipeline: loads and out-of-range accesses answer one cycle after gnt.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        logic        resp_d;
        logic        rvalid_q;
        logic        err_q;
        logic [31:0] rdata_q;

        assign resp_d = gnt[gi] && (oor || !we_w);

        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= resp_d;
                err_q    <= resp_d && oor;
                if (resp_d) begin
                    rdata_q <= oor ? 32'h0 : mem_data_r;
                end
            end
        end
    end

    assign m0_rvalid = g_resp[0].rvalid_q;
    assign m0_err    = g_resp[0].err_q;
    assign m0_rdata  = g_resp[0].rdata_q;
    assign m1_rvalid = g_resp[1].rvalid_q;
    assign m1_err    = g_resp[1].err_q;
    assign m1_rdata  = g_resp[1].rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: transaction-level arbitration model plus a DMEM model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int MEM_DEPTH = 256;
    localparam int MAX_HOLD  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [2:0]  m0_load_sel;
    logic [1:0]  m0_store_sel;
    logic        m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [2:0]  m1_load_sel;
    logic [1:0]  m1_store_sel;
    logic [31:0] mem_addr, mem_data_w, mem_data_r;
    logic [2:0]  mem_load_sel;
    logic [1:0]  mem_store_sel;
    logic        mem_wr_en;

    dmem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_load_sel(m0_load_sel), .m0_store_sel(m0_store_sel),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_load_sel(m1_load_sel), .m1_store_sel(m1_store_sel),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_data_w(mem_data_w), .mem_load_sel(mem_load_sel),
        .mem_store_sel(mem_store_sel), .mem_wr_en(mem_wr_en), .mem_data_r(mem_data_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] sel);
        case (sel)
            LOAD_SEL_B:  return {{24{w[7]}}, w[7:0]};
            LOAD_SEL_BU: return {24'h0, w[7:0]};
            LOAD_SEL_H:  return {{16{w[15]}}, w[15:0]};
            LOAD_SEL_HU: return {16'h0, w[15:0]};
            default:     return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] d,
                                                input logic [1:0] sel);
        case (sel)
            STORE_SEL_B: return {old[31:8], d[7:0]};
            STORE_SEL_H: return {old[31:16], d[15:0]};
            default:     return d;
        endcase
    endfunction

    // DMEM model driven by the DUT: combinational read, write on posedge.
    bit [31:0] env_mem [MEM_DEPTH];
    assign mem_data_r = fmt_load(env_mem[mem_addr[9:2]], mem_load_sel);
    always @(posedge clk) begin
        if (mem_wr_en == MEM_WRITE)
            env_mem[mem_addr[9:2]] <= merge_store(env_mem[mem_addr[9:2]], mem_data_w, mem_store_sel);
    end

    typedef struct {
        bit          active;
        bit          lock;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  lsel;
        logic [1:0]  ssel;
    } txn_t;
    typedef struct { int due; logic [31:0] rdata; bit err; } resp_t;
    typedef struct { logic [1:0] gnt; logic wr_en; logic [31:0] addr; } gexp_t;

    txn_t      pend [2];
    resp_t     rq0 [$];
    resp_t     rq1 [$];
    gexp_t     gq [$];
    bit [31:0] ref_mem [MEM_DEPTH];
    int        n_vec = 0;
    int        n_bad = 0;

    // Reference arbitration state: current lock owner, its grant streak, the barred port.
    int own    = -1;
    int streak = 0;
    int ban    = -1;
`ifdef DMEM_ARB_RR_EN
    int last   = 1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic post(input int p, input bit lock, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] lsel, input logic [1:0] ssel);
        pend[p].active = 1'b1;
        pend[p].lock   = lock;
        pend[p].we     = we;
        pend[p].addr   = addr;
        pend[p].wdata  = wdata;
        pend[p].lsel   = lsel;
        pend[p].ssel   = ssel;
    endtask

    task automatic drive_inputs();
        m0_req = pend[0].active; m0_lock = pend[0].lock; m0_we = pend[0].we;
        m0_addr = pend[0].addr; m0_wdata = pend[0].wdata;
        m0_load_sel = pend[0].lsel; m0_store_sel = pend[0].ssel;
        m1_req = pend[1].active; m1_lock = pend[1].lock; m1_we = pend[1].we;
        m1_addr = pend[1].addr; m1_wdata = pend[1].wdata;
        m1_load_sel = pend[1].lsel; m1_store_sel = pend[1].ssel;
    endtask

    function automatic int model_pick();
        bit r0, r1, e0, e1;
        r0 = pend[0].active;
        r1 = pend[1].active;
        if (own == 0 && r0) return 0;
        if (own == 1 && r1) return 1;
        e0 = r0 && !(ban == 0 && r1);
        e1 = r1 && !(ban == 1 && r0);
        if (e0 && e1) begin
`ifdef DMEM_ARB_RR_EN
            return (last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    // One bus cycle: drive inputs, predict grant/response, advance the reference model.
    task automatic step(input bit do_rst);
        int          w;
        gexp_t       g;
        resp_t       r;
        logic [31:0] a;
        bit          oor;
        @(posedge clk);
        #2;
        rst = do_rst;
        drive_inputs();
        g.gnt = 2'b00; g.wr_en = ~MEM_WRITE; g.addr = 32'h0;
        if (do_rst) begin
            own = -1; streak = 0; ban = -1;
`ifdef DMEM_ARB_RR_EN
            last = 1;
`endif
            gq.push_back(g);
            return;
        end
        w = model_pick();
        if (w < 0) begin
            own = -1; streak = 0; ban = -1;
        end else begin
            a   = pend[w].addr;
            oor = (a[31:2] >= 30'(MEM_DEPTH));
            g.gnt  = (w == 1) ? 2'b10 : 2'b01;
            g.addr = a;
            r.due = cyc + 1; r.err = oor; r.rdata = 32'h0;
            if (!oor && pend[w].we) begin
                g.wr_en = MEM_WRITE;
                ref_mem[a[9:2]] = merge_store(ref_mem[a[9:2]], pend[w].wdata, pend[w].ssel);
            end
            if (oor || !pend[w].we) begin
                if (!oor) r.rdata = fmt_load(ref_mem[a[9:2]], pend[w].lsel);
                if (w == 0) rq0.push_back(r); else rq1.push_back(r);
            end
            streak = (w == own) ? streak + 1 : 1;
            if (pend[w].lock && streak < MAX_HOLD) begin
                own = w; ban = -1;
            end else begin
                own = -1; streak = 0;
                ban = pend[w].lock ? w : -1;
            end
`ifdef DMEM_ARB_RR_EN
            last = w;
`endif
            pend[w].active = 1'b0;
        end
        gq.push_back(g);
    endtask

    task automatic run_until_idle();
        int n = 0;
        while ((pend[0].active || pend[1].active) && n < 64) begin
            step(1'b0);
            n++;
        end
        if (pend[0].active || pend[1].active) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout cyc=%0d got=pending want=idle", cyc);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(MEM_DEPTH, 4 * MEM_DEPTH - 1)) << 2;
        else                           a = 32'($urandom_range(0, MEM_DEPTH - 1)) << 2;
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    // Monitor: every cycle pop the expected grant and compare responses when due.
    initial begin : monitor
        gexp_t       g;
        resp_t       e;
        bit          has;
        logic        rv, er;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            if (gq.size() > 0) begin
                g = gq.pop_front();
                chk("gnt", 32'({m1_gnt, m0_gnt}), 32'(g.gnt));
                chk("mem_wr_en", 32'(mem_wr_en), 32'(g.wr_en));
                if (g.gnt != 2'b00) chk("mem_addr", mem_addr, g.addr);
            end
            for (int p = 0; p < 2; p++) begin
                has = 1'b0;
                e.rdata = 32'h0; e.err = 1'b0; e.due = 0;
                if (p == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin e = rq0.pop_front(); has = 1'b1; end
                if (p == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin e = rq1.pop_front(); has = 1'b1; end
                rv = (p == 0) ? m0_rvalid : m1_rvalid;
                rd = (p == 0) ? m0_rdata  : m1_rdata;
                er = (p == 0) ? m0_err    : m1_err;
                chk((p == 0) ? "rvalid0" : "rvalid1", 32'(rv), 32'(has));
                if (has && rv === 1'b1) begin
                    chk((p == 0) ? "rdata0" : "rdata1", rd, e.rdata);
                    chk((p == 0) ? "err0" : "err1", 32'(er), 32'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin : driver
        for (int p = 0; p < 2; p++) post(p, 1'b0, 1'b0, 32'h0, 32'h0, LOAD_SEL_W, STORE_SEL_W);
        pend[0].active = 1'b0;
        pend[1].active = 1'b0;
        drive_inputs();

        repeat (3) step(1'b1);
        step(1'b0);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata, 32'h0);
        chk("rst_err", 32'({m1_err, m0_err}), 32'h0);

        // Word 0xA5A50080 at 0x10, then a sign-extending byte load from m0.
        post(1, 1'b0, 1'b1, 32'h10, 32'hA5A5_0080, LOAD_SEL_W, STORE_SEL_W);
        run_until_idle();
        post(0, 1'b0, 1'b0, 32'h10, 32'h0, LOAD_SEL_B, STORE_SEL_W);
        run_until_idle();

        // Simultaneous unlocked requests, twice.
        repeat (2) begin
            post(0, 1'b0, 1'b0, 32'h10, 32'h0, LOAD_SEL_W, STORE_SEL_W);
            post(1, 1'b0, 1'b0, 32'h10, 32'h0, LOAD_SEL_H, STORE_SEL_W);
            run_until_idle();
        end

        // m1 locked stream with m0 waiting: cap forces m0 in, then m1 re-owns.
        for (int i = 0; i < 9; i++) begin
            if (!pend[1].active) post(1, 1'b1, 1'b0, 32'(i * 4), 32'h0, LOAD_SEL_W, STORE_SEL_W);
            if (i == 1) post(0, 1'b0, 1'b0, 32'h10, 32'h0, LOAD_SEL_HU, STORE_SEL_W);
            step(1'b0);
        end
        post(1, 1'b0, 1'b0, 32'h10, 32'h0, LOAD_SEL_W, STORE_SEL_W);
        run_until_idle();

        // Out-of-range store.
        post(0, 1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, LOAD_SEL_W, STORE_SEL_W);
        run_until_idle();

        // Reset in the middle of an m1 lock with its load still in flight.
        post(1, 1'b1, 1'b0, 32'h10, 32'h0, LOAD_SEL_W, STORE_SEL_W);
        step(1'b0);
        post(1, 1'b1, 1'b0, 32'h14, 32'h0, LOAD_SEL_W, STORE_SEL_W);
        step(1'b1);
        step(1'b0);
        post(1, 1'b0, 1'b0, 32'h18, 32'h0, LOAD_SEL_W, STORE_SEL_W);
        run_until_idle();

        // Byte store then unsigned byte load, back to back.
        post(0, 1'b0, 1'b1, 32'h20, 32'h0000_0077, LOAD_SEL_W, STORE_SEL_B);
        step(1'b0);
        post(0, 1'b0, 1'b0, 32'h20, 32'h0, LOAD_SEL_BU, STORE_SEL_W);
        run_until_idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].active && $urandom_range(0, 99) < 45)
                    post(p, ($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1, rand_addr(),
                         $urandom(), 3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)));
            end
            step($urandom_range(0, 299) == 0);
        end
        run_until_idle();
        repeat (3) step(1'b0);
        @(negedge clk);
        #1;

        chk("resp_left0", 32'(rq0.size()), 32'h0);
        chk("resp_left1", 32'(rq1.size()), 32'h0);
        for (int i = 0; i < MEM_DEPTH; i++) chk("dmem_word", env_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
